cpu_wr_decode: RTL and testbench

//  Upstream front end of the register-write stage. Brings the asynchronous active-low CPU

---
 rtl/cpu_bus_pkg.sv | 22 ++
 rtl/strobe_sync.sv | 31 +++
 rtl/cpu_wr_decode.sv | 167 ++++++++++++++++
 tb/tb_cpu_wr_decode.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared CPU bus FSM states, strobe polarity and default register map
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAPT   = 3'd1,
    ST_DECODE = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERRW   = 3'd4
  } wr_state_e;

  // CPU strobes are active low; the idle level is also the synchronizer reset value
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam logic [3:0] DEF_REG1_ADDR = 4'h1;
  localparam logic [3:0] DEF_REG2_ADDR = 4'h2;
  localparam logic [3:0] DEF_REG3_ADDR = 4'h3;

  localparam int NUM_REGS = 3;

endpackage

// File: rtl/strobe_sync.sv
// rtl/strobe_sync.sv - multi-flop synchronizer for one async active-low strobe
// Resets to the strobe's idle (high) level so a reset never looks like an access.
module strobe_sync
  import cpu_bus_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_in,
  output logic strobe_s
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], strobe_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{STROBE_OFF}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign strobe_s = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_wr_decode.sv
// rtl/cpu_wr_decode.sv - CPU write front end: strobe sync, capture, decode, held write pulse
// Outputs are registered from the next state so they change cleanly on clock edges.
module cpu_wr_decode
  import cpu_bus_pkg::*;
#(
  parameter int                ADDR_W      = 4,
  parameter logic [ADDR_W-1:0] REG1_ADDR   = ADDR_W'(DEF_REG1_ADDR),
  parameter logic [ADDR_W-1:0] REG2_ADDR   = ADDR_W'(DEF_REG2_ADDR),
  parameter logic [ADDR_W-1:0] REG3_ADDR   = ADDR_W'(DEF_REG3_ADDR),
  parameter int                SYNC_STAGES = 2,
  parameter int                HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS_,
  input  logic              WE_,
  input  logic              OE_,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  output logic [7:0]        data_out,
  output logic              my_wr,
  output logic              CS_reg1,
  output logic              CS_reg2,
  output logic              CS_reg3,
  output logic              bus_err
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic cs_s, we_s, oe_s;
  logic wr_act, ovl;

  wr_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  cap_vld_q, cap_vld_d;
  logic [NUM_REGS-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  my_wr_q, my_wr_d;
  logic [NUM_REGS-1:0]   cs_reg_q, cs_reg_d;
  logic [7:0]            data_out_q, data_out_d;
  logic                  bus_err_q, bus_err_d;
  logic [NUM_REGS-1:0]   hit_sel;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .strobe_in(CS_), .strobe_s(cs_s)
  );
  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_we (
    .clk(clk), .rst(rst), .strobe_in(WE_), .strobe_s(we_s)
  );
  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_oe (
    .clk(clk), .rst(rst), .strobe_in(OE_), .strobe_s(oe_s)
  );

  assign wr_act = (cs_s == STROBE_ON) && (we_s == STROBE_ON);
  assign ovl    = wr_act && (oe_s == STROBE_ON);

  // Priority order resolves colliding register addresses in favour of reg1
  always_comb begin
    hit_sel = '0;
    if (addr_q == REG1_ADDR) begin
      hit_sel = 3'b001;
    end else if (addr_q == REG2_ADDR) begin
      hit_sel = 3'b010;
    end else if (addr_q == REG3_ADDR) begin
      hit_sel = 3'b100;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cap_vld_d = cap_vld_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ovl) begin
          state_d   = ST_ERRW;
          bus_err_d = 1'b1;
        end else if (wr_act) begin
          state_d   = ST_CAPT;
          cap_vld_d = 1'b0;
        end
      end
      ST_CAPT: begin
        if (ovl) begin
          state_d   = ST_ERRW;
          bus_err_d = 1'b1;
        end else if (wr_act) begin
          addr_d    = addr;
          wdata_d   = data;
          cap_vld_d = 1'b1;
        end else begin
          // A strobe too short to be sampled in CAPT carries no trustworthy data
          state_d = cap_vld_q ? ST_DECODE : ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (hit_sel != '0) begin
          state_d = ST_COMMIT;
          sel_d   = hit_sel;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ERRW: begin
        if (!wr_act) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    my_wr_d    = (state_d == ST_COMMIT);
    cs_reg_d   = my_wr_d ? sel_d : '0;
    data_out_d = my_wr_d ? wdata_q : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      cap_vld_q  <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= '0;
      my_wr_q    <= 1'b0;
      cs_reg_q   <= '0;
      data_out_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cap_vld_q  <= cap_vld_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      my_wr_q    <= my_wr_d;
      cs_reg_q   <= cs_reg_d;
      data_out_q <= data_out_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign my_wr    = my_wr_q;
  assign CS_reg1  = cs_reg_q[0];
  assign CS_reg2  = cs_reg_q[1];
  assign CS_reg3  = cs_reg_q[2];
  assign data_out = data_out_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_cpu_wr_decode.sv
// tb/tb_cpu_wr_decode.sv - self-checking bench for cpu_wr_decode
module tb_cpu_wr_decode;

  localparam int SYNC = 2;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       CS_ = 1'b1;
  logic       WE_ = 1'b1;
  logic       OE_ = 1'b1;
  logic [3:0] addr = '0;
  logic [7:0] data = '0;
  logic [7:0] data_out;
  logic       my_wr, CS_reg1, CS_reg2, CS_reg3, bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  int         obs_wr_cnt, obs_first, obs_err, obs_onehot_bad, edge_ctr;
  logic [2:0] obs_sel;
  logic [7:0] obs_data;
  logic [7:0] model_last = 8'h00;

  typedef struct packed {
    int         wr_cnt;
    int         first;
    logic [2:0] sel;
    int         err;
    logic [7:0] dout;
  } exp_t;

  cpu_wr_decode #(
    .ADDR_W(4), .REG1_ADDR(4'h1), .REG2_ADDR(4'h2), .REG3_ADDR(4'h3),
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .CS_(CS_), .WE_(WE_), .OE_(OE_), .addr(addr), .data(data),
    .data_out(data_out), .my_wr(my_wr), .CS_reg1(CS_reg1), .CS_reg2(CS_reg2),
    .CS_reg3(CS_reg3), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a write either is dropped, errors, or produces one held window
  function automatic exp_t ref_model(logic [3:0] a, logic [7:0] d, int low, bit ov,
                                     logic [7:0] prev);
    exp_t e;
    e.wr_cnt = 0; e.first = -1; e.sel = 3'b000; e.err = 0; e.dout = prev;
    if (low < SYNC + 1) return e;
    if (ov) begin
      e.err = 1;
      return e;
    end
    if (a >= 4'd1 && a <= 4'd3) begin
      e.wr_cnt = HOLD;
      e.first  = SYNC + 2;
      e.sel    = 3'(1 << (a - 1));
      e.dout   = d;
    end else begin
      e.err = 1;
    end
    return e;
  endfunction

  task automatic tick(input bit after_rise);
    @(negedge clk);
    if (my_wr) begin
      obs_wr_cnt++;
      if (after_rise && obs_first < 0) obs_first = edge_ctr;
      obs_sel  = obs_sel | {CS_reg3, CS_reg2, CS_reg1};
      obs_data = data_out;
    end
    if (bus_err) obs_err++;
    if ($countones({CS_reg3, CS_reg2, CS_reg1}) > 1 ||
        (!my_wr && {CS_reg3, CS_reg2, CS_reg1} != 3'b000)) obs_onehot_bad++;
    @(posedge clk);
    #1;
    edge_ctr++;
  endtask

  task automatic run_txn(input logic [3:0] a, input logic [7:0] d, input int low,
                         input bit ov, input int post);
    obs_wr_cnt = 0; obs_first = -1; obs_err = 0; obs_onehot_bad = 0;
    obs_sel = 3'b000; obs_data = 8'h00;
    addr = a; data = d; CS_ = 1'b0; WE_ = 1'b0; OE_ = ov ? 1'b0 : 1'b1;
    repeat (low) tick(1'b0);
    CS_ = 1'b1; WE_ = 1'b1; OE_ = 1'b1;
    edge_ctr = 0;
    repeat (post) tick(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++; if (my_wr !== 1'b0) begin n_bad++; $display("FAIL reset_my_wr got %b want 0", my_wr); end
    n_cmp++; if ({CS_reg3, CS_reg2, CS_reg1} !== 3'b000) begin n_bad++; $display("FAIL reset_cs got %b want 000", {CS_reg3, CS_reg2, CS_reg1}); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out got %h want 00", data_out); end
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_write();
    exp_t e;
    e = ref_model(4'h1, 8'hA5, 6, 1'b0, model_last);
    run_txn(4'h1, 8'hA5, 6, 1'b0, 12);
    model_last = e.dout;
    n_cmp++; if (obs_wr_cnt !== HOLD) begin n_bad++; $display("FAIL single_wr_cnt got %0d want %0d", obs_wr_cnt, HOLD); end
    n_cmp++; if (obs_first !== 4) begin n_bad++; $display("FAIL single_latency got %0d want 4", obs_first); end
    n_cmp++; if (obs_sel !== 3'b001) begin n_bad++; $display("FAIL single_sel got %b want 001", obs_sel); end
    n_cmp++; if (obs_data !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", obs_data); end
    n_cmp++; if (obs_err !== 0 || obs_onehot_bad !== 0) begin n_bad++; $display("FAIL single_err got err=%0d onehot_bad=%0d want 0/0", obs_err, obs_onehot_bad); end
  endtask

  task automatic test_unmapped();
    exp_t e;
    e = ref_model(4'h9, 8'h3C, 6, 1'b0, model_last);
    run_txn(4'h9, 8'h3C, 6, 1'b0, 12);
    model_last = e.dout;
    n_cmp++; if (obs_err !== e.err) begin n_bad++; $display("FAIL unmapped_err got %0d want %0d", obs_err, e.err); end
    n_cmp++; if (obs_wr_cnt !== 0) begin n_bad++; $display("FAIL unmapped_wr got %0d want 0", obs_wr_cnt); end
    n_cmp++; if (data_out !== e.dout) begin n_bad++; $display("FAIL unmapped_data_out got %h want %h", data_out, e.dout); end
  endtask

  task automatic test_overlap();
    exp_t e;
    e = ref_model(4'h2, 8'hEE, 5, 1'b1, model_last);
    run_txn(4'h2, 8'hEE, 5, 1'b1, 12);
    model_last = e.dout;
    n_cmp++; if (obs_err !== 1) begin n_bad++; $display("FAIL overlap_err got %0d want 1", obs_err); end
    n_cmp++; if (obs_wr_cnt !== 0) begin n_bad++; $display("FAIL overlap_wr got %0d want 0", obs_wr_cnt); end
    e = ref_model(4'h3, 8'h11, 5, 1'b0, model_last);
    run_txn(4'h3, 8'h11, 5, 1'b0, 12);
    model_last = e.dout;
    n_cmp++; if (obs_sel !== 3'b100 || obs_data !== 8'h11) begin n_bad++; $display("FAIL overlap_then_wr got sel=%b data=%h want 100/11", obs_sel, obs_data); end
    n_cmp++; if (obs_wr_cnt !== HOLD || obs_err !== 0) begin n_bad++; $display("FAIL overlap_then_wr_cnt got wr=%0d err=%0d want %0d/0", obs_wr_cnt, obs_err, HOLD); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a_tab [2] = '{4'h2, 4'h1};
    logic [7:0] d_tab [2] = '{8'h01, 8'h02};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e = ref_model(a_tab[i], d_tab[i], 4, 1'b0, model_last);
      run_txn(a_tab[i], d_tab[i], 4, 1'b0, HOLD + 4);
      model_last = e.dout;
      n_cmp++; if (obs_wr_cnt !== e.wr_cnt || obs_first !== e.first) begin n_bad++; $display("FAIL b2b_%0d_window got cnt=%0d first=%0d want %0d/%0d", i, obs_wr_cnt, obs_first, e.wr_cnt, e.first); end
      n_cmp++; if (obs_sel !== e.sel || obs_data !== e.dout) begin n_bad++; $display("FAIL b2b_%0d_sel_data got %b/%h want %b/%h", i, obs_sel, obs_data, e.sel, e.dout); end
    end
  endtask

  task automatic test_rst_abort();
    exp_t e;
    obs_wr_cnt = 0; obs_first = -1; obs_err = 0; obs_onehot_bad = 0; obs_sel = 3'b000;
    addr = 4'h2; data = 8'h77; CS_ = 1'b0; WE_ = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; CS_ = 1'b1; WE_ = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({my_wr, CS_reg3, CS_reg2, CS_reg1, bus_err} !== 5'b0 || data_out !== 8'h00) begin n_bad++; $display("FAIL rst_abort_outputs got wr=%b cs=%b err=%b data=%h want all 0", my_wr, {CS_reg3, CS_reg2, CS_reg1}, bus_err, data_out); end
    model_last = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    edge_ctr = 0;
    repeat (12) tick(1'b1);
    n_cmp++; if (obs_wr_cnt !== 0 || obs_err !== 0) begin n_bad++; $display("FAIL rst_abort_no_wr got wr=%0d err=%0d want 0/0", obs_wr_cnt, obs_err); end
    e = ref_model(4'h1, 8'h5A, 5, 1'b0, model_last);
    run_txn(4'h1, 8'h5A, 5, 1'b0, 12);
    model_last = e.dout;
    n_cmp++; if (obs_sel !== 3'b001 || obs_data !== 8'h5A || obs_wr_cnt !== HOLD) begin n_bad++; $display("FAIL rst_abort_recover got sel=%b data=%h cnt=%0d want 001/5a/%0d", obs_sel, obs_data, obs_wr_cnt, HOLD); end
  endtask

  task automatic test_short_pulse();
    run_txn(4'h1, 8'hC3, 1, 1'b0, 12);
    n_cmp++; if (obs_wr_cnt !== 0 || obs_err !== 0) begin n_bad++; $display("FAIL short_pulse got wr=%0d err=%0d want 0/0", obs_wr_cnt, obs_err); end
    n_cmp++; if (data_out !== model_last) begin n_bad++; $display("FAIL short_pulse_data_out got %h want %h", data_out, model_last); end
  endtask

  task automatic test_random();
    exp_t       e;
    logic [3:0] a;
    logic [7:0] d;
    int         low;
    bit         ov;
    for (int i = 0; i < 12; i++) begin
      ov  = ($urandom_range(0, 3) == 0);
      a   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
      d   = 8'($urandom);
      low = (!ov && $urandom_range(0, 4) == 0) ? 1 : $urandom_range(3, 8);
      e = ref_model(a, d, low, ov, model_last);
      run_txn(a, d, low, ov, 12);
      model_last = e.dout;
      n_cmp++; if (obs_wr_cnt !== e.wr_cnt || obs_err !== e.err) begin n_bad++; $display("FAIL rand_%0d_counts a=%h low=%0d ov=%0b got wr=%0d err=%0d want %0d/%0d", i, a, low, ov, obs_wr_cnt, obs_err, e.wr_cnt, e.err); end
      n_cmp++; if (obs_first !== e.first || obs_sel !== e.sel || obs_onehot_bad !== 0) begin n_bad++; $display("FAIL rand_%0d_window got first=%0d sel=%b bad=%0d want %0d/%b/0", i, obs_first, obs_sel, obs_onehot_bad, e.first, e.sel); end
      n_cmp++; if (data_out !== e.dout) begin n_bad++; $display("FAIL rand_%0d_data_out got %h want %h", i, data_out, e.dout); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_unmapped();
    test_overlap();
    test_back_to_back();
    test_rst_abort();
    test_short_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
